even_count_checker: RTL and testbench
=====================================

# even_count_checker

Downstream monitor for the 8-bit even down-counter. Samples the counter's output bus in the system clock domain and checks every sample: bit 0 must be 0, and each new value must be the previous one minus 2, modulo 2^WIDTH. It locks after a run of correct steps, flags parity and step errors, detects wrap-around, and keeps saturating and wrapping statistics counters for software.

## Interface
- WIDTH, 8, width of the monitored count bus
- LOCK_CNT, 3, number of consecutive correct steps needed to enter LOCK (1..15)
- ERR_W, 8, width of the saturating error counter
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- cnt_in  input  WIDTH  sampled counter value (synchronous to clk, stable while cnt_valid)
- cnt_valid  input  1  cnt_in is a sample this cycle
- clr  input  1  synchronous clear of err_count and wrap_count
- locked  output  1  FSM is in LOCK
- parity_err  output  1  one-cycle pulse: sample had bit 0 = 1
- step_err  output  1  one-cycle pulse: in LOCK, even sample was neither hold nor expected step
- wrap  output  1  one-cycle pulse: accepted step from 0 to 2^WIDTH-2
- err_count  output  ERR_W  count of flagged samples, saturates at all-ones
- wrap_count  output  16  count of wrap events, wraps modulo 2^16
- last_val  output  WIDTH  current reference value (last accepted sample)

## Operation
- State register: IDLE, ACQ, LOCK. Reference register `ref` (shown on last_val). Good-run counter `run` (4 bits).
- Samples are processed only in cycles where cnt_valid=1. Other cycles change nothing except clr.
- Sample classes, tested in this priority order:
  - parity: cnt_in[0]=1
  - hold: cnt_in == ref, in ACQ or LOCK
  - step: cnt_in == ref-2 mod 2^WIDTH
  - jump: any other even value
- IDLE:
  - parity → parity_err; stay in IDLE.
  - even → ref:=cnt_in, run:=0, go to ACQ.
- ACQ:
  - parity → parity_err; run:=0; ref unchanged.
  - hold → no effect.
  - step → ref:=cnt_in, run:=run+1. When run+1 == LOCK_CNT, go to LOCK.
  - jump → ref:=cnt_in, run:=0, no flag.
- LOCK:
  - parity → parity_err; run:=0; go to ACQ; ref unchanged.
  - hold → no effect.
  - step → ref:=cnt_in.
  - jump → step_err; ref:=cnt_in; run:=0; go to ACQ.
- wrap pulses on any step class sample (ACQ or LOCK) with ref==0 and cnt_in==2^WIDTH-2. wrap_count increments on the same sample.
- err_count increments by 1 for each sample that raises parity_err or step_err (at most one per sample). It holds at 2^ERR_W-1.
- clr=1 sets err_count and wrap_count to 0 on the next edge. clr wins over a same-cycle increment. clr does not affect the FSM, ref, or run.

## Timing
- All outputs are registered. Flags, counters, locked and last_val update on the clk edge that samples cnt_valid=1, so they are visible 1 cycle after the sample.
- Pulses last exactly 1 cycle. Back-to-back bad samples give back-to-back pulses.
- Reset (rst=0, any time, asynchronous):
  - state goes to IDLE
  - ref, run, err_count, wrap_count, last_val go to 0
  - locked, parity_err, step_err, wrap go to 0
- Release is synchronous to the next clk edge. A sample present on the release edge is ignored.
- Reset in mid-LOCK drops locked immediately, without waiting for clk.
- Total latency from sample to lock: LOCK_CNT+1 valid samples (the first sample sets the reference) plus 1 cycle.

## Test plan
- Lock: after reset, samples 10,8,6,4 on consecutive cycles → locked=1 one cycle after 4, last_val=4, no flags, err_count=0.
- Wrap: locked at 2, then samples 0,254,252 → wrap pulses once, one cycle after 254; wrap_count=1; locked stays 1.
- Step error: locked at 6, then sample 20 → step_err pulse, locked=0, err_count=1, last_val=20. Then 18,16,14 → relock.
- Parity and hold: locked at 8; samples 8,8,5 → no flags for the holds; on 5, parity_err pulse, locked=0, last_val=8, err_count=1.
- Saturation and clr: 300 odd samples → err_count=255. Then clr together with one more odd sample → err_count=0 and parity_err still pulses.
- Reset mid-operation: assert rst while locked with err_count=3 → all outputs 0 at once, before the next clk edge. After release, sample 6 → still IDLE → ACQ, locked=0.

Source files
------------

// File: rtl/even_count_checker_if.sv
// Sample/status bundle between a down-counter source and the even_count_checker monitor.
interface even_count_checker_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned ERR_W = 8
);
  logic [WIDTH-1:0] cnt_in;
  logic             cnt_valid;
  logic             clr;
  logic             locked;
  logic             parity_err;
  logic             step_err;
  logic             wrap;
  logic [ERR_W-1:0] err_count;
  logic [15:0]      wrap_count;
  logic [WIDTH-1:0] last_val;

  // Sample source / software side
  modport master (
    output cnt_in, cnt_valid, clr,
    input  locked, parity_err, step_err, wrap, err_count, wrap_count, last_val
  );

  // Monitor side
  modport slave (
    input  cnt_in, cnt_valid, clr,
    output locked, parity_err, step_err, wrap, err_count, wrap_count, last_val
  );
endinterface

// File: rtl/even_count_checker.sv
// Monitor for an even down-counter: checks parity and -2 steps, locks on a good run,
// flags errors, detects wrap-around and keeps error/wrap statistics.
module even_count_checker #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned ERR_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  even_count_checker_if.slave  bus
);

  localparam int unsigned RUN_W = 4;
  localparam logic [WIDTH-1:0] WRAP_VAL = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             locked_q, locked_d;
  logic             parity_q, parity_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [15:0]      wrapc_q, wrapc_d;

  logic             is_parity;
  logic             is_hold;
  logic             is_step;
  logic [WIDTH-1:0] ref_minus2;
  logic [RUN_W-1:0] run_inc;

  // Sample classification against the current reference
  always_comb begin
    ref_minus2 = WIDTH'(ref_q - WIDTH'(2));
    run_inc    = RUN_W'(run_q + RUN_W'(1));
    is_parity  = bus.cnt_in[0];
    is_hold    = (state_q != IDLE) && (bus.cnt_in == ref_q);
    is_step    = (bus.cnt_in == ref_minus2);
  end

  // Next-state, reference, run, flag and statistics logic
  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    run_d    = run_q;
    parity_d = 1'b0;
    step_d   = 1'b0;
    wrap_d   = 1'b0;
    err_d    = err_q;
    wrapc_d  = wrapc_q;

    if (bus.cnt_valid) begin
      unique case (state_q)
        IDLE: begin
          if (is_parity) begin
            parity_d = 1'b1;
          end else begin
            ref_d   = bus.cnt_in;
            run_d   = '0;
            state_d = ACQ;
          end
        end
        ACQ: begin
          if (is_parity) begin
            parity_d = 1'b1;
            run_d    = '0;
          end else if (is_hold) begin
            state_d = ACQ;
          end else if (is_step) begin
            ref_d  = bus.cnt_in;
            run_d  = run_inc;
            wrap_d = (ref_q == '0) && (bus.cnt_in == WRAP_VAL);
            if (run_inc == LOCK_RUN) state_d = LOCK;
          end else begin
            ref_d = bus.cnt_in;
            run_d = '0;
          end
        end
        LOCK: begin
          if (is_parity) begin
            parity_d = 1'b1;
            run_d    = '0;
            state_d  = ACQ;
          end else if (is_hold) begin
            state_d = LOCK;
          end else if (is_step) begin
            ref_d  = bus.cnt_in;
            wrap_d = (ref_q == '0) && (bus.cnt_in == WRAP_VAL);
          end else begin
            step_d  = 1'b1;
            ref_d   = bus.cnt_in;
            run_d   = '0;
            state_d = ACQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    locked_d = (state_d == LOCK);

    // One count per flagged sample, holding at all-ones
    if ((parity_d || step_d) && (err_q != ERR_MAX)) err_d = ERR_W'(err_q + ERR_W'(1));
    if (wrap_d) wrapc_d = 16'(wrapc_q + 16'd1);

    // Software clear wins over a same-cycle increment
    if (bus.clr) begin
      err_d   = '0;
      wrapc_d = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ref_q    <= '0;
      run_q    <= '0;
      locked_q <= 1'b0;
      parity_q <= 1'b0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      err_q    <= '0;
      wrapc_q  <= '0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      run_q    <= run_d;
      locked_q <= locked_d;
      parity_q <= parity_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
      err_q    <= err_d;
      wrapc_q  <= wrapc_d;
    end
  end

  assign bus.locked     = locked_q;
  assign bus.parity_err = parity_q;
  assign bus.step_err   = step_q;
  assign bus.wrap       = wrap_q;
  assign bus.err_count  = err_q;
  assign bus.wrap_count = wrapc_q;
  assign bus.last_val   = ref_q;

endmodule

// File: tb/tb_even_count_checker.sv
// Directed bench for even_count_checker: lock, wrap, step error, parity/hold,
// saturation with clear, and asynchronous reset.
module tb_even_count_checker;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  even_count_checker_if #(.WIDTH(8), .ERR_W(8)) bus ();

  even_count_checker #(
    .WIDTH   (8),
    .LOCK_CNT(3),
    .ERR_W   (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one valid sample for one clock, then sample outputs 1 time unit after the edge
  task automatic sample(input logic [7:0] v);
    bus.cnt_valid = 1'b1;
    bus.cnt_in    = v;
    @(posedge clk);
    #1;
    bus.cnt_valid = 1'b0;
  endtask

  // Assert reset for two edges and release it between edges
  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    bus.cnt_in    = '0;
    bus.cnt_valid = 1'b0;
    bus.clr       = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", 32'(bus.locked), 0);
    chk("rst_last_val", 32'(bus.last_val), 0);
    chk("rst_err_count", 32'(bus.err_count), 0);
    chk("rst_wrap_count", 32'(bus.wrap_count), 0);
    chk("rst_parity", 32'(bus.parity_err), 0);
    rst = 1'b1;

    // Lock: 10,8,6,4
    sample(8'd10);
    chk("lock_first_locked", 32'(bus.locked), 0);
    chk("lock_first_last", 32'(bus.last_val), 10);
    sample(8'd8);
    sample(8'd6);
    chk("lock_pre_locked", 32'(bus.locked), 0);
    sample(8'd4);
    chk("lock_locked", 32'(bus.locked), 1);
    chk("lock_last_val", 32'(bus.last_val), 4);
    chk("lock_parity", 32'(bus.parity_err), 0);
    chk("lock_step_err", 32'(bus.step_err), 0);
    chk("lock_err_count", 32'(bus.err_count), 0);

    // Wrap: locked at 2, then 0,254,252
    sample(8'd2);
    sample(8'd0);
    chk("wrap_before", 32'(bus.wrap), 0);
    sample(8'd254);
    chk("wrap_pulse", 32'(bus.wrap), 1);
    chk("wrap_count", 32'(bus.wrap_count), 1);
    chk("wrap_locked", 32'(bus.locked), 1);
    chk("wrap_last_val", 32'(bus.last_val), 254);
    sample(8'd252);
    chk("wrap_after", 32'(bus.wrap), 0);
    chk("wrap_count_hold", 32'(bus.wrap_count), 1);
    chk("wrap_locked_after", 32'(bus.locked), 1);

    // Step error: locked at 6, then 20, then relock on 18,16,14
    do_reset();
    sample(8'd14);
    sample(8'd12);
    sample(8'd10);
    sample(8'd8);
    sample(8'd6);
    chk("serr_pre_locked", 32'(bus.locked), 1);
    sample(8'd20);
    chk("serr_pulse", 32'(bus.step_err), 1);
    chk("serr_locked", 32'(bus.locked), 0);
    chk("serr_err_count", 32'(bus.err_count), 1);
    chk("serr_last_val", 32'(bus.last_val), 20);
    sample(8'd18);
    chk("serr_pulse_end", 32'(bus.step_err), 0);
    sample(8'd16);
    chk("relock_not_yet", 32'(bus.locked), 0);
    sample(8'd14);
    chk("relock_locked", 32'(bus.locked), 1);
    chk("relock_err_count", 32'(bus.err_count), 1);

    // Parity and hold: locked at 8, then 8,8,5
    do_reset();
    sample(8'd14);
    sample(8'd12);
    sample(8'd10);
    sample(8'd8);
    chk("hold_pre_locked", 32'(bus.locked), 1);
    sample(8'd8);
    chk("hold1_parity", 32'(bus.parity_err), 0);
    chk("hold1_step", 32'(bus.step_err), 0);
    chk("hold1_locked", 32'(bus.locked), 1);
    sample(8'd8);
    chk("hold2_step", 32'(bus.step_err), 0);
    chk("hold2_last", 32'(bus.last_val), 8);
    sample(8'd5);
    chk("par_pulse", 32'(bus.parity_err), 1);
    chk("par_locked", 32'(bus.locked), 0);
    chk("par_last_val", 32'(bus.last_val), 8);
    chk("par_err_count", 32'(bus.err_count), 1);
    @(posedge clk);
    #1;
    chk("par_pulse_end", 32'(bus.parity_err), 0);
    chk("idle_no_change", 32'(bus.err_count), 1);

    // Saturation: 300 odd samples, back-to-back pulses
    for (int i = 0; i < 300; i++) begin
      sample(8'd1);
      chk("sat_pulse", 32'(bus.parity_err), 1);
      if (i == 253) chk("sat_254", 32'(bus.err_count), 255);
    end
    chk("sat_err_count", 32'(bus.err_count), 255);
    chk("sat_last_val", 32'(bus.last_val), 8);

    // Clear together with another odd sample
    bus.clr = 1'b1;
    sample(8'd3);
    bus.clr = 1'b0;
    chk("clr_err_count", 32'(bus.err_count), 0);
    chk("clr_parity", 32'(bus.parity_err), 1);
    chk("clr_wrap_count", 32'(bus.wrap_count), 0);

    // Build err_count=3, lock, then reset asynchronously
    sample(8'd1);
    sample(8'd1);
    sample(8'd1);
    chk("pre_rst_err", 32'(bus.err_count), 3);
    sample(8'd6);
    sample(8'd4);
    sample(8'd2);
    chk("pre_rst_locked", 32'(bus.locked), 1);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_locked", 32'(bus.locked), 0);
    chk("arst_err_count", 32'(bus.err_count), 0);
    chk("arst_last_val", 32'(bus.last_val), 0);
    chk("arst_parity", 32'(bus.parity_err), 0);
    chk("arst_step", 32'(bus.step_err), 0);
    chk("arst_wrap", 32'(bus.wrap), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sample(8'd6);
    chk("post_rst_locked", 32'(bus.locked), 0);
    chk("post_rst_last", 32'(bus.last_val), 6);
    sample(8'd4);
    chk("post_rst_acq", 32'(bus.locked), 0);
    chk("post_rst_err", 32'(bus.err_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
